// File: rtl/dac_update_arbiter.sv
// Captures six setpoint updates into shadow registers and feeds them, one at a time in
// round-robin order, to a shared DAC write engine over a req/ack/done handshake.
module dac_update_arbiter #(
  parameter int unsigned DW             = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [5:0]      upd_strobe,
  input  logic [6*DW-1:0] upd_data,
  output logic            dac_req,
  output logic [2:0]      dac_channel,
  output logic [DW-1:0]   dac_data,
  input  logic            dac_ack,
  input  logic            dac_done,
  output logic [5:0]      pending,
  output logic            busy,
  output logic [5:0]      err_overrun,
  output logic            err_timeout,
  input  logic            err_clr
);

  localparam int unsigned NumCh = 6;
  localparam int unsigned CntW  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e          state;
  logic [DW-1:0]   shadow [NumCh];
  logic [2:0]      rr_ptr;
  logic [CntW-1:0] cnt;

  logic            sel_valid;
  logic [2:0]      sel_idx;
  logic [DW-1:0]   sel_data;
  logic [3:0]      cand;
  logic            grant;
  logic            timeout_hit;
  logic [5:0]      pending_d;
  logic [5:0]      ovr_set;

  assign busy = (state != StIdle);

  // First pending channel strictly after the last granted one, wrapping modulo NumCh.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = 3'd0;
    cand      = 4'd0;
    for (int k = 1; k <= NumCh; k++) begin
      cand = {1'b0, rr_ptr} + 4'(k);
      if (cand >= 4'(NumCh)) cand = cand - 4'(NumCh);
      if (!sel_valid && pending[cand[2:0]]) begin
        sel_valid = 1'b1;
        sel_idx   = cand[2:0];
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NumCh; i++) begin
      if (sel_idx == 3'(i)) sel_data = shadow[i];
    end
  end

  assign grant       = (state == StIdle) && sel_valid;
  assign timeout_hit = (state != StIdle) && (cnt == CntLast) &&
                       !((state == StWait) && dac_done);

  // A grant clears pending; a same-cycle strobe re-arms it without counting as an overrun.
  always_comb begin
    pending_d = pending;
    ovr_set   = '0;
    for (int i = 0; i < NumCh; i++) begin
      if (grant && (sel_idx == 3'(i))) pending_d[i] = 1'b0;
      if (timeout_hit && (dac_channel == 3'(i))) pending_d[i] = 1'b1;
      if (upd_strobe[i]) begin
        pending_d[i] = 1'b1;
        if (pending[i] && !(grant && (sel_idx == 3'(i)))) ovr_set[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= StIdle;
      for (int i = 0; i < NumCh; i++) shadow[i] <= '0;
      pending     <= '0;
      rr_ptr      <= 3'd5;
      dac_req     <= 1'b0;
      dac_channel <= 3'd0;
      dac_data    <= '0;
      cnt         <= '0;
      err_overrun <= '0;
      err_timeout <= 1'b0;
    end else begin
      pending     <= pending_d;
      err_overrun <= (err_clr ? 6'b0 : err_overrun) | ovr_set;
      err_timeout <= (err_timeout & ~err_clr) | timeout_hit;
      for (int i = 0; i < NumCh; i++) begin
        if (upd_strobe[i]) shadow[i] <= upd_data[i*DW +: DW];
      end

      case (state)
        StIdle: begin
          if (grant) begin
            dac_channel <= sel_idx;
            dac_data    <= sel_data;
            rr_ptr      <= sel_idx;
            dac_req     <= 1'b1;
            cnt         <= '0;
            state       <= StIssue;
          end
        end
        StIssue: begin
          if (timeout_hit) begin
            dac_req <= 1'b0;
            state   <= StIdle;
          end else begin
            cnt <= cnt + 1'b1;
            if (dac_ack) begin
              dac_req <= 1'b0;
              state   <= StWait;
            end
          end
        end
        StWait: begin
          if (dac_done) begin
            state <= StIdle;
          end else if (timeout_hit) begin
            dac_req <= 1'b0;
            state   <= StIdle;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          dac_req <= 1'b0;
          state   <= StIdle;
        end
      endcase
    end
  end

endmodule
